// File: rtl/rob_pkg.sv
// Shared ROB ID-allocation types.
// Default widths used by the unique-ID allocator and its front-end scheduler,
// the ID and requester-index typedefs at those defaults, and the slot
// encoding for the allocator's shared request port.
package rob_pkg;

    localparam int ID_WIDTH_DEF   = 4;
    localparam int NUM_REQ_DEF    = 4;
    localparam int FREE_DEPTH_DEF = 4;

    typedef logic [ID_WIDTH_DEF-1:0]          id_t;
    typedef logic [$clog2(NUM_REQ_DEF)-1:0]   req_idx_t;

    // Which operation owns the allocator port this cycle.
    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_ALLOC,
        SLOT_FREE
    } slot_e;

endpackage

// File: rtl/free_fifo.sv
// Synchronous FIFO holding unique IDs waiting to be released.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (empties the FIFO)
//   push, din  write request/data; ignored while full (no bypass)
//   pop        read request; ignored while empty
//   full       no room for another entry
//   empty      no entries
//   head       oldest entry (valid only while !empty)
module free_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/id_alloc_sched.sv
// Scheduler in front of the ROB unique-ID allocator.
// Round-robin arbitrates NUM_REQ alloc requesters onto the allocator's single
// port, queues returning frees in a small FIFO, and issues at most one of
// alloc/free per cycle. Completions come back as registered one-cycle pulses.
// Ports:
//   clk, rst                          clock, async active-high reset
//   req_valid/req_orig_id/req_ready   requester side (ready is one-hot or 0)
//   rsp_valid/rsp_idx/rsp_unique_id   alloc completion pulse, one cycle later
//   free_valid/free_unique_id/free_ready  release requests into the FIFO
//   freed_valid/freed_unique_id/freed_orig_id  free completion pulse
//   alloc_req/alloc_orig_id, alloc_gnt/alloc_unique_id/id_matrix_full
//                                     allocator alloc interface
//   free_req/free_id, restored_id     allocator free interface
module id_alloc_sched
    import rob_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int ID_WIDTH   = ID_WIDTH_DEF,
    parameter int FREE_DEPTH = FREE_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ID_WIDTH-1:0] req_orig_id,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_idx,
    output logic [ID_WIDTH-1:0]         rsp_unique_id,
    input  logic                        free_valid,
    input  logic [ID_WIDTH-1:0]         free_unique_id,
    output logic                        free_ready,
    output logic                        freed_valid,
    output logic [ID_WIDTH-1:0]         freed_unique_id,
    output logic [ID_WIDTH-1:0]         freed_orig_id,
    output logic                        alloc_req,
    output logic [ID_WIDTH-1:0]         alloc_orig_id,
    input  logic                        alloc_gnt,
    input  logic [ID_WIDTH-1:0]         alloc_unique_id,
    input  logic                        id_matrix_full,
    output logic                        free_req,
    output logic [ID_WIDTH-1:0]         free_id,
    input  logic [ID_WIDTH-1:0]         restored_id
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]    rr_ptr;
    logic                pri;
    logic [IDX_W-1:0]    cand;
    logic                cand_found;
    logic                have_alloc;
    logic                have_free;
    logic                accept;
    slot_e               slot;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ID_WIDTH-1:0] fifo_head;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned idx_u;
        idx_u      = 0;
        cand       = '0;
        cand_found = 1'b0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx_u = (32'(rr_ptr) + off) % NUM_REQ;
            if (!cand_found && req_valid[IDX_W'(idx_u)]) begin
                cand_found = 1'b1;
                cand       = IDX_W'(idx_u);
            end
        end
    end

    assign have_alloc = cand_found & ~id_matrix_full;
    assign have_free  = ~fifo_empty;

    // The port is forced idle while reset is held so the allocator sees
    // no requests during reset, even with requesters still asserting valid.
    always_comb begin
        slot = SLOT_IDLE;
        if (!rst) begin
            if (have_alloc && have_free) slot = pri ? SLOT_ALLOC : SLOT_FREE;
            else if (have_alloc)         slot = SLOT_ALLOC;
            else if (have_free)          slot = SLOT_FREE;
        end
    end

    always_comb begin
        alloc_req     = (slot == SLOT_ALLOC);
        alloc_orig_id = '0;
        if (alloc_req) alloc_orig_id = req_orig_id[int'(cand)*ID_WIDTH +: ID_WIDTH];
        accept    = alloc_req & alloc_gnt;
        req_ready = '0;
        if (accept) req_ready[cand] = 1'b1;
        free_req = (slot == SLOT_FREE);
        free_id  = free_req ? fifo_head : '0;
    end

    assign free_ready = ~fifo_full;

    free_fifo #(
        .DEPTH (FREE_DEPTH),
        .WIDTH (ID_WIDTH)
    ) u_free_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (free_valid),
        .pop   (free_req),
        .din   (free_unique_id),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr          <= '0;
            pri             <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_idx         <= '0;
            rsp_unique_id   <= '0;
            freed_valid     <= 1'b0;
            freed_unique_id <= '0;
            freed_orig_id   <= '0;
        end else begin
            // Pointer only moves on an accepted alloc so a blocked
            // requester keeps its turn.
            if (accept) rr_ptr <= (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
            if (have_alloc && have_free) pri <= ~pri;
            rsp_valid       <= accept;
            rsp_idx         <= accept ? cand : '0;
            rsp_unique_id   <= accept ? alloc_unique_id : '0;
            freed_valid     <= free_req;
            freed_unique_id <= free_req ? fifo_head : '0;
            freed_orig_id   <= free_req ? restored_id : '0;
        end
    end

endmodule

// File: tb/tb_id_alloc_sched.sv
module tb_id_alloc_sched;
    import rob_pkg::*;

    localparam int N = 4;
    localparam int W = 4;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_orig_id;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    req_idx_t       rsp_idx;
    id_t            rsp_unique_id;
    logic           free_valid;
    id_t            free_unique_id;
    logic           free_ready;
    logic           freed_valid;
    id_t            freed_unique_id;
    id_t            freed_orig_id;
    logic           alloc_req;
    id_t            alloc_orig_id;
    logic           alloc_gnt;
    id_t            alloc_unique_id;
    logic           id_matrix_full;
    logic           free_req;
    id_t            free_id;
    id_t            restored_id;

    // Allocator stub: the restored original ID is a fixed scramble of free_id.
    assign restored_id = free_id ^ 4'hA;

    always #5 clk = ~clk;

    id_alloc_sched #(
        .NUM_REQ    (N),
        .ID_WIDTH   (W),
        .FREE_DEPTH (D)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_orig_id     (req_orig_id),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_idx         (rsp_idx),
        .rsp_unique_id   (rsp_unique_id),
        .free_valid      (free_valid),
        .free_unique_id  (free_unique_id),
        .free_ready      (free_ready),
        .freed_valid     (freed_valid),
        .freed_unique_id (freed_unique_id),
        .freed_orig_id   (freed_orig_id),
        .alloc_req       (alloc_req),
        .alloc_orig_id   (alloc_orig_id),
        .alloc_gnt       (alloc_gnt),
        .alloc_unique_id (alloc_unique_id),
        .id_matrix_full  (id_matrix_full),
        .free_req        (free_req),
        .free_id         (free_id),
        .restored_id     (restored_id)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    int q[$];
    int rr;
    bit pri;
    bit e_rsp_v;
    int e_rsp_idx, e_rsp_uid;
    bit e_fr_v;
    int e_fr_uid, e_fr_orig;
    logic [N-1:0] obs_ready;
    int full_seen;

    task automatic model_reset();
        q.delete();
        rr = 0; pri = 0;
        e_rsp_v = 0; e_rsp_idx = 0; e_rsp_uid = 0;
        e_fr_v = 0; e_fr_uid = 0; e_fr_orig = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_rsp_valid",   rsp_valid, 0);
        chk("rst_rsp_idx",     rsp_idx, 0);
        chk("rst_rsp_uid",     rsp_unique_id, 0);
        chk("rst_freed_valid", freed_valid, 0);
        chk("rst_freed_uid",   freed_unique_id, 0);
        chk("rst_freed_orig",  freed_orig_id, 0);
        chk("rst_alloc_req",   alloc_req, 0);
        chk("rst_free_req",    free_req, 0);
        chk("rst_req_ready",   req_ready, 0);
        chk("rst_free_ready",  free_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // One clock of stimulus: inputs held from just after one rising edge to
    // just after the next; outputs checked on the falling edge in between.
    task automatic cycle(input logic [N-1:0] v, input logic full, input logic gnt,
                         input logic fv, input logic [W-1:0] fid);
        int  cand, e_ready, e_aorig, e_fid;
        bit  ha, hf, ga, gf, was_full;
        logic [W-1:0] uid;
        req_valid      = v;
        id_matrix_full = full;
        alloc_gnt      = gnt;
        uid            = W'($urandom);
        alloc_unique_id = uid;
        free_valid     = fv;
        free_unique_id = fid;
        @(negedge clk);
        chk("rsp_valid",   rsp_valid, e_rsp_v);
        chk("rsp_idx",     rsp_idx, e_rsp_idx);
        chk("rsp_uid",     rsp_unique_id, e_rsp_uid);
        chk("freed_valid", freed_valid, e_fr_v);
        chk("freed_uid",   freed_unique_id, e_fr_uid);
        chk("freed_orig",  freed_orig_id, e_fr_orig);

        cand = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (rr + k) % N;
            if (cand < 0 && v[i]) cand = i;
        end
        ha = (cand >= 0) && !full;
        hf = (q.size() > 0);
        ga = ha && (!hf || pri);
        gf = hf && (!ha || !pri);
        e_ready = (ga && gnt) ? (1 << cand) : 0;
        e_aorig = ga ? int'(req_orig_id[cand*W +: W]) : 0;
        e_fid   = gf ? q[0] : 0;
        chk("alloc_req",     alloc_req, ga);
        chk("alloc_orig_id", alloc_orig_id, e_aorig);
        chk("req_ready",     req_ready, e_ready);
        chk("free_req",      free_req, gf);
        chk("free_id",       free_id, e_fid);
        chk("free_ready",    free_ready, (q.size() < D) ? 1 : 0);
        chk("excl",          alloc_req & free_req, 0);
        obs_ready = req_ready;
        if (!free_ready) full_seen++;

        @(posedge clk);
        e_rsp_v   = ga && gnt;
        e_rsp_idx = (ga && gnt) ? cand : 0;
        e_rsp_uid = (ga && gnt) ? int'(uid) : 0;
        if (ga && gnt) rr = (cand + 1) % N;
        was_full = (q.size() >= D);
        if (gf) begin
            e_fr_v = 1; e_fr_uid = q[0]; e_fr_orig = q[0] ^ 'hA;
            void'(q.pop_front());
        end else begin
            e_fr_v = 0; e_fr_uid = 0; e_fr_orig = 0;
        end
        if (fv && !was_full) q.push_back(int'(fid));
        if (ha && hf) pri = !pri;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        req_valid = '0; req_orig_id = '0; free_valid = 1'b0; free_unique_id = '0;
        alloc_gnt = 1'b0; alloc_unique_id = '0; id_matrix_full = 1'b0;
        model_reset();
        do_reset();

        // Round robin with all requesters valid
        req_orig_id = {4'd9, 4'd7, 4'd5, 4'd3};
        for (int k = 0; k < 5; k++) begin
            cycle(4'hF, 1'b0, 1'b1, 1'b0, '0);
            chk("rr_order", obs_ready, 1 << (k % 4));
        end

        // Blocked requester keeps its turn
        for (int k = 0; k < 2; k++) begin
            cycle(4'b0100, 1'b1, 1'b1, 1'b0, '0);
            chk("blk_ready", obs_ready, 0);
        end
        cycle(4'b0100, 1'b0, 1'b1, 1'b0, '0);
        chk("blk_first", obs_ready, 4'b0100);

        // No row available: retried until granted
        for (int k = 0; k < 2; k++) begin
            cycle(4'b0001, 1'b0, 1'b0, 1'b0, '0);
            chk("norow_ready", obs_ready, 0);
        end
        cycle(4'b0001, 1'b0, 1'b1, 1'b0, '0);
        chk("norow_retry", obs_ready, 4'b0001);

        // Contention with continuous frees until the FIFO fills
        full_seen = 0;
        for (int k = 0; k < 12; k++) cycle(4'b0001, 1'b0, 1'b1, 1'b1, W'($urandom));
        chk("fifo_filled", (full_seen > 0) ? 1 : 0, 1);

        // Drain, then contention without new frees
        for (int k = 0; k < 2; k++) cycle('0, 1'b0, 1'b1, 1'b0, '0);
        for (int k = 0; k < 6; k++) cycle(4'b0001, 1'b0, 1'b1, 1'b0, '0);
        for (int k = 0; k < 4; k++) cycle('0, 1'b0, 1'b1, 1'b0, '0);

        // Randomized traffic with a reset in the middle
        for (int k = 0; k < 240; k++) begin
            if (k % 16 == 0) req_orig_id = (N*W)'($urandom);
            if (k == 120) do_reset();
            cycle(N'($urandom), ($urandom % 5) == 0, ($urandom % 4) != 0,
                  ($urandom % 3) != 0, W'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
